// File: rtl/udp_pkt_gen_pkg.sv
// Shared constants, FSM encoding and the per-byte header template
// for the VLAN/IPv4/UDP test packet generator.
package udp_pkt_gen_pkg;

    // Ethertype as it appears on tdata[143:128] (byte 16 = 08, byte 17 = 00).
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0008;
    localparam logic [7:0]  IPPROT_UDP    = 8'h11;
    localparam logic [15:0] TPID_VLAN     = 16'h8100;
    localparam logic [15:0] VLAN_VID      = 16'h0001;
    localparam logic [47:0] MAC_DST       = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_SRC       = 48'h02_00_00_00_00_02;
    localparam logic [31:0] IP_SRC        = 32'h0a_00_00_01;
    localparam logic [31:0] IP_DST        = 32'h0a_00_00_02;
    localparam logic [15:0] UDP_SPORT     = 16'h04d2;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_TTL        = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pkt_state_e;

    // Byte value at packet offset o; multi-byte fields are big-endian on the wire.
    function automatic logic [7:0] pkt_byte(input int o, input logic [15:0] len,
                                            input logic [31:0] seq, input logic [15:0] dport);
        logic [15:0] ip_len;
        logic [15:0] udp_len;
        logic [7:0]  b;
        ip_len  = len - 16'd18;
        udp_len = len - 16'd38;
        b       = 8'(o);
        if (o < 6)       b = 8'(MAC_DST >> (8 * (5 - o)));
        else if (o < 12) b = 8'(MAC_SRC >> (8 * (11 - o)));
        else if (o < 14) b = 8'(TPID_VLAN >> (8 * (13 - o)));
        else if (o < 16) b = 8'(VLAN_VID >> (8 * (15 - o)));
        else if (o < 18) b = 8'(ETH_TYPE_IPV4 >> (8 * (o - 16)));
        else begin
            case (o)
                18:             b = IP_VER_IHL;
                20:             b = ip_len[15:8];
                21:             b = ip_len[7:0];
                26:             b = IP_TTL;
                27:             b = IPPROT_UDP;
                30, 31, 32, 33: b = 8'(IP_SRC >> (8 * (33 - o)));
                34, 35, 36, 37: b = 8'(IP_DST >> (8 * (37 - o)));
                38, 39:         b = 8'(UDP_SPORT >> (8 * (39 - o)));
                40:             b = dport[15:8];
                41:             b = dport[7:0];
                42:             b = udp_len[15:8];
                43:             b = udp_len[7:0];
                46, 47, 48, 49: b = 8'(seq >> (8 * (49 - o)));
                19, 22, 23, 24, 25, 28, 29, 44, 45: b = 8'h00;
                default:        b = 8'(o);
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/pkt_gen_beat_fmt.sv
// Combinational beat formatter: builds one 32-byte beat of the test packet
// from its beat index; bytes past the packet end are zero with tkeep cleared.
module pkt_gen_beat_fmt
    import udp_pkt_gen_pkg::*;
(
    input  logic [5:0]   beat_idx,
    input  logic [15:0]  pkt_len,
    input  logic [31:0]  seq,
    input  logic [15:0]  dport,
    output logic [255:0] tdata,
    output logic [31:0]  tkeep
);

    always_comb begin
        tdata = '0;
        tkeep = '0;
        for (int n = 0; n < 32; n++) begin
            int off;
            off = 32 * int'(beat_idx) + n;
            if (off < int'(pkt_len)) begin
                tkeep[n]        = 1'b1;
                tdata[8*n +: 8] = pkt_byte(off, pkt_len, seq, dport);
            end
        end
    end

endmodule

// File: rtl/udp_pkt_gen.sv
// AXI-Stream source of VLAN-tagged IPv4/UDP test packets with programmable
// count, length, inter-packet gap and destination port.
module udp_pkt_gen
    import udp_pkt_gen_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MIN_LEN              = 64,
    parameter int MAX_LEN              = 2048
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_start,
    input  logic                              cfg_stop,
    input  logic [31:0]                       cfg_num_pkts,
    input  logic [15:0]                       cfg_pkt_len,
    input  logic [15:0]                       cfg_gap,
    input  logic [15:0]                       cfg_udp_dport,
    input  logic [7:0]                        cfg_src_port,
    output logic                              busy,
    output logic [31:0]                       pkts_sent,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    pkt_state_e state_q, state_d;
    logic [5:0]  beat_q, beat_d;
    logic [31:0] pkts_q, pkts_d;
    logic [31:0] num_q, num_d;
    logic [15:0] len_q, len_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] dport_q, dport_d;
    logic [7:0]  src_q, src_d;
    logic        stop_q, stop_d;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep_q, tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
    logic                             tvalid_q, tvalid_d;
    logic                             tlast_q, tlast_d;

    logic [255:0] fmt_tdata;
    logic [31:0]  fmt_tkeep;
    logic         hs;

    // Valid/ready: a beat moves when tvalid && tready; otherwise every output
    // register holds, because none of the next-beat inputs change without hs.
    assign hs = (state_q == ST_SEND) && m_axis_tready;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pkts_d    = pkts_q;
        num_d     = num_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        dport_d   = dport_q;
        src_d     = src_q;
        stop_d    = stop_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                    pkts_d  = '0;
                    stop_d  = 1'b0;
                    num_d   = cfg_num_pkts;
                    gap_d   = cfg_gap;
                    dport_d = cfg_udp_dport;
                    src_d   = cfg_src_port;
                    if (cfg_pkt_len < 16'(MIN_LEN))      len_d = 16'(MIN_LEN);
                    else if (cfg_pkt_len > 16'(MAX_LEN)) len_d = 16'(MAX_LEN);
                    else                                 len_d = cfg_pkt_len;
                end
            end
            ST_SEND: begin
                if (cfg_stop) stop_d = 1'b1;
                if (hs) begin
                    if (tlast_q) begin
                        pkts_d = pkts_q + 32'd1;
                        beat_d = '0;
                        if (stop_d || (num_q != '0 && pkts_d == num_q)) begin
                            state_d = ST_IDLE;
                            stop_d  = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            ST_GAP: begin
                if (stop_q || cfg_stop) begin
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                end else if (gap_cnt_q == 16'd1) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The sequence number of the packet on the bus equals pkts_sent.
    pkt_gen_beat_fmt u_fmt (
        .beat_idx (beat_d),
        .pkt_len  (len_d),
        .seq      (pkts_d),
        .dport    (dport_d),
        .tdata    (fmt_tdata),
        .tkeep    (fmt_tkeep)
    );

    always_comb begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tkeep_d  = '0;
        tuser_d  = '0;
        tlast_d  = 1'b0;
        if (state_d == ST_SEND) begin
            tvalid_d = 1'b1;
            tdata_d  = fmt_tdata;
            tkeep_d  = fmt_tkeep;
            tlast_d  = ({5'b0, beat_d, 5'b0} + 16'd32) >= len_d;
            if (beat_d == '0) tuser_d = {{(C_S_AXIS_TUSER_WIDTH-24){1'b0}}, src_d, len_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            pkts_q    <= '0;
            num_q     <= '0;
            len_q     <= 16'(MIN_LEN);
            gap_q     <= '0;
            gap_cnt_q <= '0;
            dport_q   <= '0;
            src_q     <= '0;
            stop_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tuser_q   <= '0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            pkts_q    <= pkts_d;
            num_q     <= num_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            dport_q   <= dport_d;
            src_q     <= src_d;
            stop_q    <= stop_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign pkts_sent     = pkts_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_udp_pkt_gen.sv
// Directed bench for udp_pkt_gen: golden byte model per packet, expected
// beat queues, stall-stability and inter-packet gap monitoring.
module tb_udp_pkt_gen;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_start = 1'b0;
    logic         cfg_stop = 1'b0;
    logic [31:0]  cfg_num_pkts = '0;
    logic [15:0]  cfg_pkt_len = '0;
    logic [15:0]  cfg_gap = '0;
    logic [15:0]  cfg_udp_dport = '0;
    logic [7:0]   cfg_src_port = '0;
    logic         busy;
    logic [31:0]  pkts_sent;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;

    udp_pkt_gen dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_gap       (cfg_gap),
        .cfg_udp_dport (cfg_udp_dport),
        .cfg_src_port  (cfg_src_port),
        .busy          (busy),
        .pkts_sent     (pkts_sent),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [255:0] exp_q[$];
    logic [31:0]  exp_keep_q[$];
    logic [127:0] exp_user_q[$];
    logic         exp_last_q[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic flush_exp();
        exp_q.delete();
        exp_keep_q.delete();
        exp_user_q.delete();
        exp_last_q.delete();
    endtask

    // Golden packet: literal header bytes, then payload byte k = k[7:0].
    task automatic push_pkt(input int len, input int seq, input logic [15:0] dport, input logic [7:0] src);
        logic [399:0] hdr;
        logic [7:0]   pkt [0:2047];
        logic [255:0] data;
        logic [31:0]  keep;
        int           nb;
        hdr = {48'h020000000001, 48'h020000000002, 16'h8100, 16'h0001, 16'h0800,
               8'h45, 8'h00, 16'(len - 18), 32'h0, 8'h40, 8'h11, 16'h0,
               32'h0a000001, 32'h0a000002, 16'h04d2, dport, 16'(len - 38), 16'h0, 32'(seq)};
        for (int k = 0; k < len; k++)
            pkt[k] = (k < 50) ? hdr[399 - 8*k -: 8] : 8'(k);
        nb = (len + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            data = '0;
            keep = '0;
            for (int n = 0; n < 32; n++) begin
                if (b*32 + n < len) begin
                    data[8*n +: 8] = pkt[b*32 + n];
                    keep[n]        = 1'b1;
                end
            end
            exp_q.push_back(data);
            exp_keep_q.push_back(keep);
            exp_user_q.push_back((b == 0) ? {104'b0, src, 16'(len)} : 128'b0);
            exp_last_q.push_back(b == nb - 1);
        end
    endtask

    // ---------------- monitor ----------------
    int           ready_mode = 0;
    int           cur_gap = 0;
    logic         have_last = 1'b0;
    int           last_hs_cyc = 0;
    int           mon_pkt = 0;
    int           mon_beat = 0;
    logic         stalled = 1'b0;
    logic         prev_v = 1'b0;
    logic [417:0] hold = '0;

    initial begin
        logic [255:0] e_data;
        logic [255:0] mask;
        logic [31:0]  e_keep;
        logic [127:0] e_user;
        logic         e_last;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled  = 1'b0;
                prev_v   = 1'b0;
                mon_beat = 0;
            end else begin
                if (stalled)
                    check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, hold);
                if (m_axis_tvalid && !prev_v && have_last)
                    check("gap_cycles", cyc - last_hs_cyc - 1, cur_gap);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e_data = exp_q.pop_front();
                        e_keep = exp_keep_q.pop_front();
                        e_user = exp_user_q.pop_front();
                        e_last = exp_last_q.pop_front();
                        for (int n = 0; n < 32; n++) mask[8*n +: 8] = {8{e_keep[n]}};
                        check("tdata", m_axis_tdata & mask, e_data);
                        check("tkeep", m_axis_tkeep, e_keep);
                        check("tuser", m_axis_tuser, e_user);
                        check("tlast", m_axis_tlast, e_last);
                    end
                    if (mon_beat == 0) begin
                        check("ethertype", m_axis_tdata[143:128], 16'h0008);
                        check("ip_proto", m_axis_tdata[223:216], 8'h11);
                    end
                    if (m_axis_tlast) begin
                        have_last   = 1'b1;
                        last_hs_cyc = cyc;
                        mon_pkt++;
                        mon_beat = 0;
                    end else begin
                        mon_beat++;
                    end
                end
                stalled = m_axis_tvalid && !m_axis_tready;
                hold    = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
                prev_v  = m_axis_tvalid;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic set_cfg(input int num, input int len, input int gap, input logic [15:0] dport,
                           input logic [7:0] src);
        cfg_num_pkts  = 32'(num);
        cfg_pkt_len   = 16'(len);
        cfg_gap       = 16'(gap);
        cfg_udp_dport = dport;
        cfg_src_port  = src;
    endtask

    task automatic wait_idle(input int exp_sent);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("done_in_budget", done, 1);
        check("busy_drop_after_tlast", cyc - last_hs_cyc, 1);
        check("pkts_sent", pkts_sent, exp_sent);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run(input int num, input int cfg_len, input int exp_len, input int gap,
                       input logic [15:0] dport, input logic [7:0] src, input int mode);
        ready_mode = mode;
        cur_gap    = gap;
        have_last  = 1'b0;
        mon_pkt    = 0;
        for (int s = 0; s < num; s++) push_pkt(exp_len, s, dport, src);
        set_cfg(num, cfg_len, gap, dport, src);
        pulse_start();
        wait_idle(num);
        ready_mode = 0;
    endtask

    task automatic wait_beat(input int pkt, input int beat);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            if (mon_pkt == pkt && mon_beat >= beat) hit = 1'b1;
        end
        check("reach_beat", hit, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_pkts_sent", pkts_sent, 0);
        reset = 1'b0;

        // stop in IDLE has no effect
        @(negedge clk);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        @(negedge clk);
        check("idle_stop_busy", busy, 0);

        // single minimum-size packet
        run(1, 64, 64, 0, 16'd1234, 8'h05, 0);
        // 100-byte packets, gap 5, sequence numbers 0..2
        run(3, 100, 100, 5, 16'h2222, 8'h3c, 0);
        // random backpressure, 300-byte packets
        run(2, 300, 300, 3, 16'hbeef, 8'ha5, 1);
        // clamping
        run(1, 10, 64, 0, 16'h0101, 8'h01, 0);
        run(1, 9000, 2048, 0, 16'h0202, 8'h02, 0);

        // continuous mode with a start+stop pulse; stop issued during beat 2 of packet 7
        have_last = 1'b0;
        mon_pkt   = 0;
        cur_gap   = 0;
        for (int s = 0; s < 8; s++) push_pkt(100, s, 16'h0777, 8'h77);
        set_cfg(0, 100, 0, 16'h0777, 8'h77);
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        wait_beat(7, 2);
        cfg_stop = 1'b1;
        @(posedge clk);
        #1;
        cfg_stop = 1'b0;
        wait_idle(8);

        // reset in the middle of the second packet
        have_last = 1'b0;
        mon_pkt   = 0;
        push_pkt(300, 0, 16'h0999, 8'h09);
        push_pkt(300, 1, 16'h0999, 8'h09);
        set_cfg(2, 300, 0, 16'h0999, 8'h09);
        pulse_start();
        wait_beat(1, 3);
        check("pre_reset_sent", pkts_sent, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_pkts_sent", pkts_sent, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush_exp();
        run(1, 64, 64, 0, 16'h0abc, 8'h0c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
